// File: rtl/chip8_beeper_if.sv
// Signal bundle between the CHIP-8 sound timer side and the beeper.
// Used by chip8_beeper (slave modport) and by whoever drives it (master modport).
interface chip8_beeper_if;
  // No handshake: timer_val/enable are levels sampled on every rising clk edge;
  // beep_out/active are registered levels valid after each edge.
  logic [7:0] timer_val;
  logic       enable;
  logic       beep_out;
  logic       active;

  modport master (
    output timer_val,
    output enable,
    input  beep_out,
    input  active
  );

  modport slave (
    input  timer_val,
    input  enable,
    output beep_out,
    output active
  );
endinterface

// File: rtl/chip8_beeper.sv
// Square-wave beeper driven by the CHIP-8 sound timer; toggles at TONE_HZ while requested.
// Optional macro CHIP8_BEEPER_DRAIN_EN adds a DRAIN state so a stop never truncates a high half.
module chip8_beeper #(
  parameter int CLK_HZ  = 27000000,
  parameter int TONE_HZ = 440
) (
  input  logic           clk,
  input  logic           rst_n,
  chip8_beeper_if.slave  bus,
  output logic [1:0]     state_dbg_o
);

  localparam int HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

`ifdef CHIP8_BEEPER_DRAIN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          beep_q;
  logic          active_q;
  logic          req;

  // Only zero versus non-zero of the timer matters; the timer owns the countdown.
  assign req = (bus.timer_val != 8'd0) && bus.enable;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      beep_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req) begin
            state_q  <= RUN;
            beep_q   <= 1'b1;
            active_q <= 1'b1;
          end else begin
            beep_q   <= 1'b0;
            active_q <= 1'b0;
          end
        end

        RUN: begin
          if (req) begin
            if (cnt_q == LAST) begin
              cnt_q  <= '0;
              beep_q <= ~beep_q;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
`ifdef CHIP8_BEEPER_DRAIN_EN
          end else if (beep_q) begin
            // Finish the high half; counting continues on this same edge.
            if (cnt_q == LAST) begin
              state_q  <= IDLE;
              cnt_q    <= '0;
              beep_q   <= 1'b0;
              active_q <= 1'b0;
            end else begin
              state_q <= DRAIN;
              cnt_q   <= cnt_q + 1'b1;
            end
`endif
          end else begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            beep_q   <= 1'b0;
            active_q <= 1'b0;
          end
        end

`ifdef CHIP8_BEEPER_DRAIN_EN
        DRAIN: begin
          if (req) begin
            // Re-arm keeps count and phase; a wrap here toggles low and stays in RUN.
            state_q <= RUN;
            if (cnt_q == LAST) begin
              cnt_q  <= '0;
              beep_q <= ~beep_q;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (cnt_q == LAST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            beep_q   <= 1'b0;
            active_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          beep_q   <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.beep_out = beep_q;
  assign bus.active   = active_q;
  assign state_dbg_o  = state_q;

endmodule
